// File: rtl/pndes.sv
`default_nettype none
// ============================================================================
// Module   : pndes
// Purpose  : Serial frame deserializer. Hunts for HEADER, captures len+1
//            payload bits, checks FOOTER, delivers the MSB-aligned payload.
// Revision : 1.0 - initial release
// ============================================================================
module pndes #(
    parameter logic [3:0] HEADER = 4'b1101,
    parameter logic [3:0] FOOTER = 4'b0101
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dat_i,
    input  logic [4:0]  len_i,
    output logic [31:0] dat_o,
    output logic [4:0]  len_o,
    output logic        vld_o,
    output logic        err_o,
    output logic [7:0]  gcnt_o,
    output logic [7:0]  ecnt_o
);

    localparam logic [1:0] c_HUNT = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_FOOT = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_hwin;
    logic [3:0]  r_fwin;
    logic [4:0]  r_cnt;
    logic [4:0]  r_len;
    logic [31:0] r_pay;
    logic [31:0] r_dat;
    logic [4:0]  r_len_out;
    logic        r_vld;
    logic        r_err;
    logic [7:0]  r_gcnt;
    logic [7:0]  r_ecnt;

    logic [3:0]  w_hdr_cand;
    logic [3:0]  w_ftr_cand;

    assign w_hdr_cand = {r_hwin[2:0], dat_i};
    assign w_ftr_cand = {r_fwin[2:0], dat_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_HUNT;
            r_hwin    <= 4'd0;
            r_fwin    <= 4'd0;
            r_cnt     <= 5'd0;
            r_len     <= 5'd0;
            r_pay     <= 32'd0;
            r_dat     <= 32'd0;
            r_len_out <= 5'd0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
            r_gcnt    <= 8'd0;
            r_ecnt    <= 8'd0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                c_HUNT: begin
                    r_hwin <= w_hdr_cand;
                    if (w_hdr_cand == HEADER) begin
                        r_state <= c_DATA;
                        r_len   <= len_i;
                        r_cnt   <= len_i;
                        r_pay   <= 32'd0;
                    end
                end
                c_DATA: begin
                    r_pay <= {r_pay[30:0], dat_i};
                    if (r_cnt == 5'd0) begin
                        r_state <= c_FOOT;
                        r_cnt   <= 5'd3;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                c_FOOT: begin
                    r_fwin <= w_ftr_cand;
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        // Window cleared so the next frame's header may start immediately.
                        r_state <= c_HUNT;
                        r_hwin  <= 4'd0;
                        if (w_ftr_cand == FOOTER) begin
                            r_dat     <= r_pay << (5'd31 - r_len);
                            r_len_out <= r_len;
                            r_vld     <= 1'b1;
                            r_gcnt    <= r_gcnt + 8'd1;
                        end else begin
                            r_err  <= 1'b1;
                            r_ecnt <= r_ecnt + 8'd1;
                        end
                    end
                end
                default: r_state <= c_HUNT;
            endcase
        end
    end

    assign dat_o  = r_dat;
    assign len_o  = r_len_out;
    assign vld_o  = r_vld;
    assign err_o  = r_err;
    assign gcnt_o = r_gcnt;
    assign ecnt_o = r_ecnt;

endmodule
`default_nettype wire

// File: tb/tb_pndes.sv
`default_nettype none
// ============================================================================
// Module   : tb_pndes
// Purpose  : Scoreboard bench for pndes with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pndes;

    localparam logic [3:0] c_HDR = 4'b1101;
    localparam logic [3:0] c_FTR = 4'b0101;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dat_i;
    logic [4:0]  len_i;
    logic [31:0] dat_o;
    logic [4:0]  len_o;
    logic        vld_o;
    logic        err_o;
    logic [7:0]  gcnt_o;
    logic [7:0]  ecnt_o;

    pndes dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .dat_i  (dat_i),
        .len_i  (len_i),
        .dat_o  (dat_o),
        .len_o  (len_o),
        .vld_o  (vld_o),
        .err_o  (err_o),
        .gcnt_o (gcnt_o),
        .ecnt_o (ecnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          good;
        logic [31:0] dat;
        logic [4:0]  len;
        logic [7:0]  g;
        logic [7:0]  e;
    } exp_t;

    exp_t        sb[$];
    int          pulse_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        mon_x;

    logic [31:0] m_dat;
    logic [4:0]  m_len;
    logic [7:0]  m_g;
    logic [7:0]  m_e;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse is matched against the oldest outstanding frame.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && (vld_o === 1'b1 || err_o === 1'b1)) begin
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {vld_o, err_o}, 32'd0);
            end else begin
                mon_x = sb.pop_front();
                check("vld", {31'd0, vld_o}, {31'd0, mon_x.good});
                check("err", {31'd0, err_o}, {31'd0, !mon_x.good});
                check("dat", dat_o, mon_x.dat);
                check("len", {27'd0, len_o}, {27'd0, mon_x.len});
                check("gcnt", {24'd0, gcnt_o}, {24'd0, mon_x.g});
                check("ecnt", {24'd0, ecnt_o}, {24'd0, mon_x.e});
            end
        end
    end

    task automatic send_bit(input logic b, input logic [4:0] l);
        dat_i = b;
        len_i = l;
        @(posedge clk_i);
        #1;
    endtask

    // Payload p holds len+1 bits, p[len] goes on the line first.
    task automatic send_frame(input logic [4:0] len, input logic [31:0] p,
                              input logic [3:0] ftr, input int gap);
        exp_t        x;
        logic [31:0] aligned;
        aligned = 32'd0;
        for (int i = 0; i <= int'(len); i++) aligned[31-i] = p[int'(len)-i];
        if (ftr == c_FTR) begin
            m_g   = m_g + 8'd1;
            m_dat = aligned;
            m_len = len;
        end else begin
            m_e = m_e + 8'd1;
        end
        x.good = (ftr == c_FTR);
        x.dat  = m_dat;
        x.len  = m_len;
        x.g    = m_g;
        x.e    = m_e;
        sb.push_back(x);
        for (int i = 0; i < gap; i++) send_bit(1'b0, 5'($urandom));
        for (int i = 3; i >= 0; i--) send_bit(c_HDR[i], (i == 0) ? len : 5'($urandom));
        for (int i = int'(len); i >= 0; i--) send_bit(p[i], 5'($urandom));
        for (int i = 3; i >= 0; i--) send_bit(ftr[i], 5'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            send_bit(1'b0, 5'd0);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: outstanding=%0d want 0", sb.size());
            sb.delete();
        end
        send_bit(1'b0, 5'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_dat"}, dat_o, 32'd0);
        check({name, "_len"}, {27'd0, len_o}, 32'd0);
        check({name, "_pulse"}, {30'd0, vld_o, err_o}, 32'd0);
        check({name, "_cnt"}, {16'd0, gcnt_o, ecnt_o}, 32'd0);
    endtask

    initial begin
        logic [3:0]  ftr;
        logic [4:0]  l;
        int          d;
        m_dat = 32'd0; m_len = 5'd0; m_g = 8'd0; m_e = 8'd0;
        rst_i = 1'b1; dat_i = 1'b0; len_i = 5'd0;
        #2;
        check_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        send_frame(5'd3, 32'hA, c_FTR, 3);
        drain();
        check("basic_dat", dat_o, 32'hA000_0000);
        send_frame(5'd31, 32'hDEADBEEF, c_FTR, 2);
        drain();
        send_frame(5'd0, 32'h1, 4'b0111, 1);
        drain();

        // Near-miss prefix 1100 then a payload containing the header pattern.
        send_bit(1'b1, 5'd9); send_bit(1'b1, 5'd9); send_bit(1'b0, 5'd9); send_bit(1'b0, 5'd9);
        send_frame(5'd7, 32'hD6, c_FTR, 0);
        drain();

        send_frame(5'd7, 32'h5B, c_FTR, 1);
        send_frame(5'd15, 32'hD0D1, c_FTR, 0);
        drain();
        d = pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2];
        check("b2b_spacing", d, 32'd24);

        // Asynchronous reset in the middle of a payload.
        for (int i = 3; i >= 0; i--) send_bit(c_HDR[i], 5'd20);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom), 5'd20);
        #3 rst_i = 1'b1;
        #1 check_zero("midreset");
        m_dat = 32'd0; m_len = 5'd0; m_g = 8'd0; m_e = 8'd0;
        send_bit(1'b0, 5'd0); send_bit(1'b0, 5'd0);
        rst_i = 1'b0;
        send_frame(5'd4, 32'h13, c_FTR, 0);
        drain();

        // Enough random frames to wrap the good-frame counter.
        for (int k = 0; k < 300; k++) begin
            l   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ftr = ($urandom_range(0, 9) < 9) ? c_FTR : 4'($urandom);
            send_frame(l, $urandom, ftr, $urandom_range(0, 3));
        end
        drain();
        check("final_gcnt", {24'd0, gcnt_o}, {24'd0, m_g});
        check("final_ecnt", {24'd0, ecnt_o}, {24'd0, m_e});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
